// File: rtl/main_memory_model_if.sv
// Request/response handshake between cache_controller (master) and the
// main memory model (slave).
interface main_memory_model_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cache2mem_addr;
  logic [DATA_W-1:0] cache2mem_data;
  logic              cache2mem_MemRead;
  logic              cache2mem_MemWrite;
  logic [DATA_W-1:0] mem2cache_data;
  logic              mem2cache_ready;
  logic              mem_busy;

  modport master (
    output cache2mem_addr, cache2mem_data, cache2mem_MemRead, cache2mem_MemWrite,
    input  mem2cache_data, mem2cache_ready, mem_busy
  );

  modport slave (
    input  cache2mem_addr, cache2mem_data, cache2mem_MemRead, cache2mem_MemWrite,
    output mem2cache_data, mem2cache_ready, mem_busy
  );
endinterface

// File: rtl/main_memory_model.sv
// Word-addressed backing store: accepts one request at a time, holds it for
// LATENCY cycles, commits the access and pulses ready for one cycle.
module main_memory_model #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 4
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  main_memory_model_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [7:0]          cnt;
  logic [DEPTH_W-1:0]  idx;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                is_write;
  logic                req;
  logic                done;

  logic [DATA_W-1:0]   store [DEPTH] = '{default: '0};

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{bus.cache2mem_addr[ADDR_W-1:DEPTH_W+2], bus.cache2mem_addr[1:0]};

  assign req  = bus.cache2mem_MemRead | bus.cache2mem_MemWrite;
  assign done = (state == WAIT) && (cnt == 8'd0);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = WAIT;
      WAIT:    if (done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      cnt      <= 8'd0;
      rdata    <= '0;
      idx      <= '0;
      wdata    <= '0;
      is_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx      <= bus.cache2mem_addr[DEPTH_W+1:2];
            wdata    <= bus.cache2mem_data;
            is_write <= bus.cache2mem_MemWrite;
            cnt      <= 8'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt != 8'd0) cnt   <= cnt - 8'd1;
          else             rdata <= is_write ? wdata : store[idx];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the store has no reset so it maps onto block RAM; reset only
  // suppresses a write that has not yet committed.
  always_ff @(posedge iCLK) begin
    if (iRST_n && done && is_write) store[idx] <= wdata;
  end

  assign bus.mem2cache_data  = rdata;
  assign bus.mem2cache_ready = (state == RESP);
  assign bus.mem_busy        = (state != IDLE);
endmodule

// File: tb/tb_main_memory_model.sv
// Self-checking bench for main_memory_model: a timeline-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_main_memory_model;
  localparam int L       = 4;
  localparam int DEPTH_W = 10;
  localparam int DEPTH   = 1 << DEPTH_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  main_memory_model_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  main_memory_model #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_W(DEPTH_W), .LATENCY(L)
  ) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the access commits LATENCY edges after acceptance, ready is
  // visible in the cycle following the commit edge, and the edge right after
  // that cycle never accepts a request.
  bit [31:0]   mem_m [DEPTH];
  int          edge_n      = 0;
  int          accept_edge = 0;
  int          last_commit = -10;
  bit          inflight    = 1'b0;
  bit          p_wr;
  int          p_idx;
  logic [31:0] p_d;
  logic [31:0] exp_data    = '0;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      inflight    = 1'b0;
      exp_data    = '0;
      last_commit = -10;
    end else if (inflight) begin
      if (edge_n == accept_edge + L) begin
        if (p_wr) mem_m[p_idx] = p_d;
        exp_data    = mem_m[p_idx];
        last_commit = edge_n;
        inflight    = 1'b0;
      end
    end else if (edge_n != last_commit + 1 &&
                 (bus.cache2mem_MemRead || bus.cache2mem_MemWrite)) begin
      inflight    = 1'b1;
      accept_edge = edge_n;
      p_wr        = bus.cache2mem_MemWrite;
      p_idx       = int'((bus.cache2mem_addr / 4) % DEPTH);
      p_d         = bus.cache2mem_data;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("ready", {31'd0, bus.mem2cache_ready}, {31'd0, last_commit == edge_n});
      check("busy",  {31'd0, bus.mem_busy}, {31'd0, inflight || (last_commit == edge_n)});
      check("data",  bus.mem2cache_data, exp_data);
    end
  end

  task automatic drop_req();
    bus.cache2mem_MemRead  = 1'b0;
    bus.cache2mem_MemWrite = 1'b0;
  endtask

  // Issues one request and waits (bounded) for ready; edges counts from acceptance.
  task automatic transact(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got, output int edges);
    int n = 0;
    got = 'x;
    @(negedge clk);
    bus.cache2mem_addr     = a;
    bus.cache2mem_data     = d;
    bus.cache2mem_MemRead  = rd;
    bus.cache2mem_MemWrite = wr;
    forever begin
      @(negedge clk);
      n++;
      if (bus.mem2cache_ready === 1'b1) begin
        got = bus.mem2cache_data;
        break;
      end
      if (n > 64) begin
        check("ready_timeout", {31'd0, bus.mem2cache_ready}, 32'd1);
        break;
      end
    end
    drop_req();
    edges = n - 1;
  endtask

  logic [31:0] got;
  int          lat;
  int          pulses;

  initial begin
    rst_n = 1'b0;
    bus.cache2mem_addr = '0;
    bus.cache2mem_data = '0;
    drop_req();
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.mem2cache_ready}, 32'd0);
    check("rst_data",  bus.mem2cache_data, 32'd0);
    check("rst_busy",  {31'd0, bus.mem_busy}, 32'd0);
    rst_n    = 1'b1;
    checking = 1'b1;

    transact(1, 0, 32'h40, 32'h0, got, lat);
    check("rd40_data", got, 32'h0);
    check("rd40_lat", lat, L);

    transact(0, 1, 32'h10, 32'hDEADBEEF, got, lat);
    check("wr10_echo", got, 32'hDEADBEEF);
    check("wr10_lat", lat, L);
    transact(1, 0, 32'h10, 32'h0, got, lat);
    check("rd10", got, 32'hDEADBEEF);
    transact(1, 0, 32'h13, 32'h0, got, lat);
    check("rd13", got, 32'hDEADBEEF);

    transact(0, 1, 32'h1000, 32'h12345678, got, lat);
    transact(1, 0, 32'h0000, 32'h0, got, lat);
    check("alias_rd0", got, 32'h12345678);

    transact(1, 1, 32'h20, 32'hA5A5A5A5, got, lat);
    check("both_echo", got, 32'hA5A5A5A5);
    transact(1, 0, 32'h20, 32'h0, got, lat);
    check("both_rd20", got, 32'hA5A5A5A5);

    // Inputs changed one cycle after acceptance must not affect the access.
    @(negedge clk);
    bus.cache2mem_addr    = 32'h20;
    bus.cache2mem_MemRead = 1'b1;
    @(negedge clk);
    bus.cache2mem_addr     = 32'h24;
    bus.cache2mem_data     = 32'hFFFF0000;
    bus.cache2mem_MemWrite = 1'b1;
    lat = 0;
    while (bus.mem2cache_ready !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("chg_data", bus.mem2cache_data, 32'hA5A5A5A5);
    drop_req();
    @(negedge clk);
    check("chg_pulse", {31'd0, bus.mem2cache_ready}, 32'd0);
    transact(1, 0, 32'h24, 32'h0, got, lat);
    check("chg_rd24", got, 32'h0);

    // Reset two edges after acceptance drops the write.
    @(negedge clk);
    bus.cache2mem_addr     = 32'h30;
    bus.cache2mem_data     = 32'hCAFEF00D;
    bus.cache2mem_MemWrite = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drop_req();
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy",  {31'd0, bus.mem_busy}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.mem2cache_ready}, 32'd0);
    repeat (L + 2) @(negedge clk);
    transact(1, 0, 32'h30, 32'h0, got, lat);
    check("rd30_after_rst", got, 32'h0);

    // A request held high is re-accepted once per IDLE cycle.
    @(negedge clk);
    bus.cache2mem_addr    = 32'h40;
    bus.cache2mem_MemRead = 1'b1;
    pulses = 0;
    repeat (3 * L + 6) begin
      @(negedge clk);
      if (bus.mem2cache_ready === 1'b1) pulses++;
    end
    drop_req();
    check("held_pulses", pulses, 3);
    repeat (L + 2) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a  = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      transact(op != 1, op != 0, a, $urandom, got, lat);
      check("rand_lat", lat, L);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
